mem_access_ctrl: RTL and testbench

- Responder on the memory side of the microcode control unit's 2-bit `mcontrol` command.
- Decodes `mcontrol` into data-RAM read and write transactions on a single-port synchronous RAM. The RAM array lives inside this block.
- Applies configurable access latency, latches the read result and signals completion back to the sequencer.
- Sits between the control unit, the address register (AR) and the data register (DR) of the processor datapath.

---
 rtl/proc_ctrl_pkg.sv | 28 ++
 rtl/mem_access_ctrl_if.sv | 36 +++
 rtl/mem_access_ctrl_sp_sync_ram.sv | 48 ++++
 rtl/mem_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/proc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// proc_ctrl_pkg
// Shared definitions between the microcode control unit and the memory-side
// responder: mcontrol command encodings, the responder FSM state type and the
// default datapath widths.
// -----------------------------------------------------------------------------
package proc_ctrl_pkg;

  localparam logic [1:0] MC_IDLE  = 2'b00;
  localparam logic [1:0] MC_READ  = 2'b01;
  localparam logic [1:0] MC_WRITE = 2'b10;
  localparam logic [1:0] MC_RSVD  = 2'b11;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Only a real read or write starts a transaction; MC_RSVD behaves as idle.
  function automatic logic is_mem_cmd(input logic [1:0] cmd);
    return (cmd == MC_READ) || (cmd == MC_WRITE);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
// Command/data bundle between the control unit (master) and the memory access
// controller (slave).
//   mcontrol : 2-bit command (00 idle, 01 read, 10 write, 11 reserved)
//   addr     : word address from AR
//   wdata    : write data from DR
//   rdata    : read result, held until the next completed read
//   busy     : transaction in flight
//   done     : completion, held until mcontrol returns to 00
//   mem_err  : sticky out-of-range flag
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic [1:0]        mcontrol;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              done;
  logic              mem_err;

  modport master (
    output mcontrol, addr, wdata,
    input  rdata, busy, done, mem_err
  );

  modport slave (
    input  mcontrol, addr, wdata,
    output rdata, busy, done, mem_err
  );

endinterface

// File: rtl/mem_access_ctrl_sp_sync_ram.sv
// -----------------------------------------------------------------------------
// sp_sync_ram
// Single-port synchronous RAM, DATA_W x DEPTH, with write enable and a
// registered read port.
//   clk      : clock
//   rst_n    : synchronous active-low reset, clears the read register only
//   i_en     : access enable for this cycle
//   i_we     : 1 = write i_wdata, 0 = read into o_rdata
//   i_addr   : word address
//   i_wdata  : write data
//   o_rdata  : registered read data, holds between reads
// -----------------------------------------------------------------------------
module sp_sync_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the array has no reset so it maps onto RAM macros; only the
  // read register is cleared, and writes are gated by the caller.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Memory-side responder to the control unit's mcontrol command. Accepts a
// read or write on the 00 -> 01/10 edge of mcontrol while idle, waits MEM_LAT
// cycles, commits to the internal RAM and holds done until mcontrol is 00.
//   clock    : system clock
//   reset_n  : synchronous active-low reset
//   bus      : mem_access_ctrl_if.slave (mcontrol, addr, wdata in;
//              rdata, busy, done, mem_err out)
// Optional build macro MEM_ACCESS_CTRL_RANGE_CHECK_EN: addresses >= DEPTH are
// flagged, writes suppressed, reads return 0 and mem_err sticks until reset.
// Without it the RAM is indexed by the low address bits and mem_err is 0.
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  mem_access_ctrl_if.slave   bus
);

  localparam int         RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [1:0]        r_prev_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_is_write;
  logic              w_accept;
  logic              w_commit;
  logic              w_ram_en;
  logic              w_busy;
  logic              w_done;
  logic [DATA_W-1:0] w_ram_rdata;

  // Edge-triggered acceptance: a held command starts only one transaction.
  assign w_accept = (r_state == S_IDLE) && (r_prev_cmd == MC_IDLE) &&
                    is_mem_cmd(bus.mcontrol);
  // Gated by reset_n so a reset on the commit edge aborts the RAM write.
  assign w_commit = (r_state == S_ACCESS) && (r_cnt == 4'd0) && reset_n;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_prev_cmd <= MC_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev_cmd <= bus.mcontrol;
      if (w_accept) begin
        r_addr     <= bus.addr;
        r_wdata    <= bus.wdata;
        r_is_write <= (bus.mcontrol == MC_WRITE);
        r_cnt      <= LAT_M1;
      end else if ((r_state == S_ACCESS) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        w_busy = 1'b1;
        if (r_cnt == 4'd0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        if (bus.mcontrol == MC_IDLE) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef MEM_ACCESS_CTRL_RANGE_CHECK_EN
  logic r_oor;
  logic r_mem_err;
  logic r_rd_zero;
  logic w_addr_oor;

  assign w_addr_oor = ({1'b0, bus.addr} >= (ADDR_W + 1)'(DEPTH));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_oor     <= 1'b0;
      r_mem_err <= 1'b0;
      r_rd_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        r_oor <= w_addr_oor;
        if (w_addr_oor) r_mem_err <= 1'b1;
      end
      // Out-of-range reads present 0 until the next in-range read lands.
      if (w_commit && !r_is_write) r_rd_zero <= r_oor;
    end
  end

  assign w_ram_en    = w_commit && !r_oor;
  assign bus.rdata   = r_rd_zero ? '0 : w_ram_rdata;
  assign bus.mem_err = r_mem_err;
`else
  assign w_ram_en    = w_commit;
  assign bus.rdata   = w_ram_rdata;
  assign bus.mem_err = 1'b0;
`endif

  assign bus.busy = w_busy;
  assign bus.done = w_done;

  sp_sync_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk     (clock),
    .rst_n   (reset_n),
    .i_en    (w_ram_en),
    .i_we    (r_is_write),
    .i_addr  (r_addr[RAM_AW-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl with MEM_LAT=2. Inputs change 1 ns after
// a rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;
  import proc_ctrl_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int MEM_LAT = 2;
`ifdef MEM_ACCESS_CTRL_RANGE_CHECK_EN
  localparam int DEPTH = 128;
`else
  localparam int DEPTH = 256;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clock = ~clock;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_access_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] cmd, input logic [7:0] a, input logic [7:0] d);
    bus.mcontrol = cmd;
    bus.addr     = a;
    bus.wdata    = d;
  endtask

  // Accept edge plus MEM_LAT edges: afterwards the transaction sits in DONE.
  task automatic txn(input logic [1:0] cmd, input logic [7:0] a, input logic [7:0] d);
    drive(cmd, a, d);
    repeat (MEM_LAT + 1) tick();
  endtask

  task automatic release_cmd();
    bus.mcontrol = MC_IDLE;
    tick();
  endtask

  task automatic test_reset();
    drive(MC_READ, 8'h00, 8'h00);
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", bus.rdata); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err got=%b exp=0", bus.mem_err); end
    bus.mcontrol = MC_IDLE;
    reset_n = 1'b1;
    repeat (2) tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle busy got=%b exp=0", bus.busy); end
    // Preload 0x30 with 0x00; this also confirms acceptance after 00.
    drive(MC_WRITE, 8'h30, 8'h00);
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL post_reset_accept busy got=%b exp=1", bus.busy); end
    repeat (MEM_LAT) tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL post_reset_done got=%b exp=1", bus.done); end
    release_cmd();
  endtask

  task automatic test_write_read();
    drive(MC_WRITE, 8'h10, 8'hA5);
    tick();
    checks++; if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("FAIL wr_edge1 busy,done got=%b exp=10", {bus.busy, bus.done}); end
    tick();
    checks++; if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("FAIL wr_edge2 busy,done got=%b exp=10", {bus.busy, bus.done}); end
    tick();
    checks++; if ({bus.busy, bus.done} !== 2'b01) begin errors++; $display("FAIL wr_edge3 busy,done got=%b exp=01", {bus.busy, bus.done}); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL wr_rdata_unchanged got=%h exp=00", bus.rdata); end
    release_cmd();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL wr_done_release got=%b exp=0", bus.done); end
    drive(MC_READ, 8'h10, 8'h00);
    tick();
    checks++; if (bus.busy !== 1'b1 || bus.rdata !== 8'h00) begin errors++; $display("FAIL rd_edge1 busy=%b rdata=%h exp busy=1 rdata=00", bus.busy, bus.rdata); end
    tick();
    checks++; if (bus.busy !== 1'b1 || bus.rdata !== 8'h00) begin errors++; $display("FAIL rd_edge2 busy=%b rdata=%h exp busy=1 rdata=00", bus.busy, bus.rdata); end
    tick();
    checks++; if (bus.rdata !== 8'hA5 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL rd_edge3 rdata=%h done=%b busy=%b exp A5 1 0", bus.rdata, bus.done, bus.busy); end
    release_cmd();
  endtask

  task automatic test_held_command();
    drive(MC_WRITE, 8'h20, 8'h3C);
    tick();
    bus.wdata = 8'hFF;
    for (int i = 1; i < 10; i++) begin
      tick();
      if (i >= MEM_LAT) begin
        checks++; if ({bus.busy, bus.done} !== 2'b01) begin errors++; $display("FAIL held_cycle%0d busy,done got=%b exp=01", i, {bus.busy, bus.done}); end
      end
    end
    release_cmd();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL held_release done got=%b exp=0", bus.done); end
    txn(MC_READ, 8'h20, 8'h00);
    checks++; if (bus.rdata !== 8'h3C) begin errors++; $display("FAIL held_readback got=%h exp=3C", bus.rdata); end
    release_cmd();
  endtask

  task automatic test_cmd_switch();
    drive(MC_READ, 8'h10, 8'h00);
    tick();
    drive(MC_WRITE, 8'h10, 8'h11);
    repeat (MEM_LAT) tick();
    checks++; if (bus.rdata !== 8'hA5 || bus.done !== 1'b1) begin errors++; $display("FAIL switch_read rdata=%h done=%b exp A5 1", bus.rdata, bus.done); end
    release_cmd();
    txn(MC_READ, 8'h10, 8'h00);
    checks++; if (bus.rdata !== 8'hA5) begin errors++; $display("FAIL switch_no_write got=%h exp=A5", bus.rdata); end
    release_cmd();
  endtask

  task automatic test_reset_abort();
    drive(MC_WRITE, 8'h30, 8'h77);
    repeat (MEM_LAT) tick();
    reset_n = 1'b0;
    tick();
    checks++; if ({bus.busy, bus.done} !== 2'b00 || bus.rdata !== 8'h00) begin errors++; $display("FAIL abort_state busy,done=%b rdata=%h exp 00 00", {bus.busy, bus.done}, bus.rdata); end
    bus.mcontrol = MC_IDLE;
    reset_n = 1'b1;
    tick();
    txn(MC_READ, 8'h30, 8'h00);
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL abort_no_write got=%h exp=00", bus.rdata); end
    release_cmd();
  endtask

  task automatic test_reserved();
    drive(MC_RSVD, 8'h20, 8'h00);
    repeat (2) tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rsvd_not_accepted busy got=%b exp=0", bus.busy); end
    bus.mcontrol = MC_READ;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rsvd_to_read_no_edge busy got=%b exp=0", bus.busy); end
    release_cmd();
    txn(MC_READ, 8'h20, 8'h00);
    bus.mcontrol = MC_RSVD;
    tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL rsvd_holds_done got=%b exp=1", bus.done); end
    release_cmd();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rsvd_exit_done got=%b exp=0", bus.done); end
  endtask

  task automatic test_back_to_back();
    txn(MC_WRITE, 8'h40, 8'h5A);
    checks++; if (bus.rdata !== 8'h3C) begin errors++; $display("FAIL b2b_write_keeps_rdata got=%h exp=3C", bus.rdata); end
    release_cmd();
    txn(MC_READ, 8'h40, 8'h00);
    checks++; if (bus.rdata !== 8'h5A) begin errors++; $display("FAIL b2b_raw got=%h exp=5A", bus.rdata); end
    release_cmd();
  endtask

  task automatic test_range_check();
`ifdef MEM_ACCESS_CTRL_RANGE_CHECK_EN
    txn(MC_WRITE, 8'h05, 8'h99);
    release_cmd();
    checks++; if (bus.mem_err !== 1'b0) begin errors++; $display("FAIL range_inrange_err got=%b exp=0", bus.mem_err); end
    txn(MC_WRITE, 8'h85, 8'h55);
    checks++; if (bus.mem_err !== 1'b1 || bus.done !== 1'b1) begin errors++; $display("FAIL range_wr_err mem_err=%b done=%b exp 1 1", bus.mem_err, bus.done); end
    release_cmd();
    txn(MC_READ, 8'h05, 8'h00);
    checks++; if (bus.rdata !== 8'h99) begin errors++; $display("FAIL range_wr_suppressed got=%h exp=99", bus.rdata); end
    release_cmd();
    txn(MC_READ, 8'h85, 8'h00);
    checks++; if (bus.rdata !== 8'h00 || bus.done !== 1'b1) begin errors++; $display("FAIL range_rd_zero rdata=%h done=%b exp 00 1", bus.rdata, bus.done); end
    release_cmd();
    checks++; if (bus.mem_err !== 1'b1) begin errors++; $display("FAIL range_sticky got=%b exp=1", bus.mem_err); end
`else
    checks++; if (bus.mem_err !== 1'b0) begin errors++; $display("FAIL mem_err_tied got=%b exp=0", bus.mem_err); end
`endif
  endtask

  initial begin
    drive(MC_IDLE, 8'h00, 8'h00);
    test_reset();
    test_write_read();
    test_held_command();
    test_cmd_switch();
    test_reset_abort();
    test_reserved();
    test_back_to_back();
    test_range_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
